kernel_pr_dataflow_start_ctrl: RTL and testbench
================================================

// Module: kernel_pr_dataflow_start_ctrl
// PURPOSE
//  Top-level start sequencer for a kernel_pr dataflow region. Takes one region ap_start plus an
//  iteration count and writes one start token per iteration into each child process's start FIFO.
//  Keeps in-flight iterations within the FIFO depth and retires an iteration once every child has
//  reported done. Drives region ap_ready/ap_done/ap_idle back to the host control block.
// PARAMETERS
//  NUM_PROC      4   child processes (one start FIFO + one done pulse each)
//  ITER_W        32  width of iteration count and counters
//  MAX_INFLIGHT  4   max iterations issued but not retired; must be <= start FIFO DEPTH, >= 1
// PORTS
//  clk          in   1         clock
//  reset        in   1         synchronous, active-high
//  ap_start     in   1         region start, level; sampled in IDLE only
//  num_iter     in   ITER_W    iterations for this run; latched when ap_start accepted
//  ap_ready     out  1         1-cycle pulse: last iteration fully issued
//  ap_done      out  1         1-cycle pulse: last iteration retired
//  ap_idle      out  1         high in IDLE
//  start_full_n in   NUM_PROC  per-child start FIFO not-full
//  start_write  out  NUM_PROC  per-child start FIFO write strobe (write_ce tied high outside)
//  proc_done    in   NUM_PROC  per-child 1-cycle done pulse, one per iteration, in order
//  err          out  1         sticky protocol error, cleared only by reset
// BEHAVIOUR
//  Reset: state IDLE, all counters/masks 0; ap_idle=1, ap_ready=ap_done=start_write=err=0.
//  Reset mid-run: same values next cycle; tokens already in FIFOs are not recalled.
//  FSM IDLE -> ISSUE -> DRAIN -> IDLE.
//   IDLE: ap_start=1 -> latch num_iter, clear issued_cnt/retired_cnt/issue_mask.
//         num_iter==0 -> ap_ready and ap_done pulse the next cycle, stay IDLE.
//         Otherwise -> ISSUE.
//   ISSUE: an iteration may issue when (issued_cnt - retired_cnt) < MAX_INFLIGHT.
//     start_write[p] = may_issue & ~issue_mask[p] & start_full_n[p] (start_write is registered-free
//       combinational, gated by state, so it is 0 in IDLE/DRAIN).
//     issue_mask |= start_write. When the mask plus this cycle's writes covers all bits:
//       mask clears, issued_cnt++.
//     Partial writes are allowed: a child with full_n=1 is not held back by a full sibling.
//     issued_cnt reaches num_iter -> ap_ready pulse (same cycle as the final write, combinational
//       on that condition, registered 1 cycle later), then -> DRAIN.
//   DRAIN: no writes; wait until retired_cnt == num_iter.
//  Retire (active in ISSUE and DRAIN):
//    Per child p, a pending-done counter pend[p] (width clog2(MAX_INFLIGHT+1)).
//    proc_done[p] increments pend[p].
//    When all pend[p] != 0: every pend decrements and retired_cnt++.
//    Increment and decrement in the same cycle leave pend[p] unchanged.
//    retired_cnt reaches num_iter -> ap_done 1-cycle pulse next cycle, state -> IDLE.
//    A new ap_start is accepted from that IDLE cycle on, so back-to-back runs have a 1-cycle bubble.
//  Errors (err set, operation continues):
//    proc_done[p] with pend[p] == MAX_INFLIGHT.
//    proc_done in IDLE.
//    Any proc_done that would push retired_cnt past issued_cnt.
//  Arithmetic: counters are unsigned ITER_W; in-flight difference is computed ITER_W wide,
//    no wrap because retired_cnt <= issued_cnt <= num_iter.
//  ap_ready and ap_done in the same cycle are allowed (single-iteration run with fast children).
// STRUCTURE
//  Package kernel_pr_ctrl_pkg: state enum {IDLE, ISSUE, DRAIN}; function clog2.
//  Sub-module kernel_pr_done_tracker (one per child): inc/dec pending counter, nonzero flag,
//    overflow flag.
//  Top: FSM, issue mask, issued/retired counters, output pulse registers.
// TESTING
//  1 num_iter=3, all full_n=1, each child done 5 cycles after its write -> 3 writes per child,
//    ap_ready once, ap_done once after the 3rd retire, ap_idle back to 1.
//  2 num_iter=8, MAX_INFLIGHT=4, no proc_done at first -> start_write stalls after 4 writes per child;
//    each retire releases exactly one more iteration.
//  3 Hold start_full_n[2]=0 for 10 cycles, num_iter=2 -> children 0,1,3 write iteration 0 at once;
//    child 2 writes when full_n rises; issued_cnt increments only then.
//  4 num_iter=0 -> ap_ready=ap_done=1 one cycle later, no start_write, ap_idle stays 1.
//  5 Reset asserted in ISSUE after 2 iterations -> next cycle start_write=0, ap_idle=1; a fresh run
//    of num_iter=1 then completes normally.
//  6 Extra proc_done[1] while pend[1]==MAX_INFLIGHT, and a proc_done in IDLE -> err=1 and stays 1
//    until reset.

Source files
------------

// File: rtl/kernel_pr_ctrl_pkg.sv
// Shared types and helpers for the kernel_pr dataflow start sequencer.
package kernel_pr_ctrl_pkg;

  // Region sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/kernel_pr_dataflow_start_ctrl_if.sv
// Host control + child start-FIFO / done signals of the dataflow region.
// master: environment side (host and children); slave: the start sequencer.
interface kernel_pr_dataflow_start_ctrl_if #(
  parameter int NUM_PROC = 4,
  parameter int ITER_W   = 32
);
  logic                ap_start;
  logic [ITER_W-1:0]   num_iter;
  logic                ap_ready;
  logic                ap_done;
  logic                ap_idle;
  logic [NUM_PROC-1:0] start_full_n;
  logic [NUM_PROC-1:0] start_write;
  logic [NUM_PROC-1:0] proc_done;
  logic                err;

  modport master (
    output ap_start, num_iter, start_full_n, proc_done,
    input  ap_ready, ap_done, ap_idle, start_write, err
  );

  modport slave (
    input  ap_start, num_iter, start_full_n, proc_done,
    output ap_ready, ap_done, ap_idle, start_write, err
  );
endinterface

// File: rtl/kernel_pr_done_tracker.sv
// Per-child pending-done counter: counts done pulses not yet matched by a
// region-wide retire. Saturates at MAX_INFLIGHT and flags the extra pulse.
module kernel_pr_done_tracker
  import kernel_pr_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic overflow
);
  localparam int               CNT_W   = clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0] pend_r;
  logic [CNT_W-1:0] pend_nxt_s;

  // Next pending count; simultaneous inc and dec cancel out.
  always_comb begin
    pend_nxt_s = pend_r;
    if (inc && !dec) begin
      if (pend_r != CNT_MAX) begin
        pend_nxt_s = pend_r + CNT_W'(1'b1);
      end else begin
        pend_nxt_s = pend_r;
      end
    end else if (dec && !inc) begin
      if (pend_r != '0) begin
        pend_nxt_s = pend_r - CNT_W'(1'b1);
      end else begin
        pend_nxt_s = pend_r;
      end
    end else begin
      pend_nxt_s = pend_r;
    end
  end

  // Pending counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_r <= '0;
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  assign nonzero  = (pend_r != '0);
  assign overflow = inc && (pend_r == CNT_MAX);
endmodule

// File: rtl/kernel_pr_dataflow_start_ctrl.sv
// Start sequencer for a kernel_pr dataflow region: issues one start token per
// iteration to every child FIFO, bounds in-flight iterations, retires an
// iteration once all children reported done, and reports ready/done/idle.
module kernel_pr_dataflow_start_ctrl
  import kernel_pr_ctrl_pkg::*;
#(
  parameter int NUM_PROC     = 4,
  parameter int ITER_W       = 32,
  parameter int MAX_INFLIGHT = 4
) (
  input logic                          clk,
  input logic                          reset,
  kernel_pr_dataflow_start_ctrl_if.slave bus
);
  state_e              state_r, state_nxt_s;
  logic [ITER_W-1:0]   num_iter_r;
  logic [ITER_W-1:0]   issued_cnt_r;
  logic [ITER_W-1:0]   retired_cnt_r;
  logic [NUM_PROC-1:0] issue_mask_r;
  logic                ap_ready_r;
  logic                ap_done_r;
  logic                err_r;

  logic [ITER_W-1:0]   inflight_s;
  logic                may_issue_s;
  logic [NUM_PROC-1:0] start_write_s;
  logic                iter_issued_s;
  logic                last_issue_s;
  logic                retire_active_s;
  logic                all_pend_s;
  logic                retire_ok_s;
  logic                retire_bad_s;
  logic                last_retire_s;
  logic                zero_run_s;
  logic                err_set_s;
  logic [NUM_PROC-1:0] track_inc_s;
  logic [NUM_PROC-1:0] nonzero_s;
  logic [NUM_PROC-1:0] overflow_s;

  // Issue/retire decode. retired <= issued, so the difference never wraps.
  always_comb begin
    inflight_s      = issued_cnt_r - retired_cnt_r;
    may_issue_s     = (state_r == ISSUE) && (inflight_s < ITER_W'(MAX_INFLIGHT));
    start_write_s   = may_issue_s ? (~issue_mask_r & bus.start_full_n) : '0;
    iter_issued_s   = may_issue_s && (&(issue_mask_r | start_write_s));
    last_issue_s    = iter_issued_s && ((issued_cnt_r + ITER_W'(1'b1)) == num_iter_r);
    retire_active_s = (state_r == ISSUE) || (state_r == DRAIN);
    all_pend_s      = &nonzero_s;
    retire_ok_s     = retire_active_s && all_pend_s && (retired_cnt_r < issued_cnt_r);
    retire_bad_s    = retire_active_s && all_pend_s && (retired_cnt_r >= issued_cnt_r);
    last_retire_s   = retire_ok_s && ((retired_cnt_r + ITER_W'(1'b1)) == num_iter_r);
    zero_run_s      = (state_r == IDLE) && bus.ap_start && (bus.num_iter == '0);
    track_inc_s     = bus.proc_done & {NUM_PROC{retire_active_s}};
    err_set_s       = (|overflow_s) || retire_bad_s ||
                      ((state_r == IDLE) && (|bus.proc_done));
  end

  // One pending-done tracker per child.
  for (genvar p = 0; p < NUM_PROC; p++) begin : g_trk
    kernel_pr_done_tracker #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_trk (
      .clk      (clk),
      .reset    (reset),
      .inc      (track_inc_s[p]),
      .dec      (retire_ok_s),
      .nonzero  (nonzero_s[p]),
      .overflow (overflow_s[p])
    );
  end

  // Next-state logic: IDLE -> ISSUE -> DRAIN -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.ap_start && (bus.num_iter != '0)) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (last_issue_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      DRAIN: begin
        if (last_retire_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Run counters, issue mask, status pulses and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      num_iter_r    <= '0;
      issued_cnt_r  <= '0;
      retired_cnt_r <= '0;
      issue_mask_r  <= '0;
      ap_ready_r    <= 1'b0;
      ap_done_r     <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      ap_ready_r <= zero_run_s || last_issue_s;
      ap_done_r  <= zero_run_s || last_retire_s;
      err_r      <= err_r || err_set_s;
      if ((state_r == IDLE) && bus.ap_start) begin
        num_iter_r    <= bus.num_iter;
        issued_cnt_r  <= '0;
        retired_cnt_r <= '0;
        issue_mask_r  <= '0;
      end else begin
        if (iter_issued_s) begin
          issued_cnt_r <= issued_cnt_r + ITER_W'(1'b1);
          issue_mask_r <= '0;
        end else begin
          issue_mask_r <= issue_mask_r | start_write_s;
        end
        if (retire_ok_s) begin
          retired_cnt_r <= retired_cnt_r + ITER_W'(1'b1);
        end
      end
    end
  end

  assign bus.start_write = start_write_s;
  assign bus.ap_ready    = ap_ready_r;
  assign bus.ap_done     = ap_done_r;
  assign bus.ap_idle     = (state_r == IDLE);
  assign bus.err         = err_r;
endmodule

// File: tb/tb_kernel_pr_dataflow_start_ctrl.sv
// Scoreboard bench for the kernel_pr dataflow start sequencer. Stimulus pushes
// the expected active-cycle events (cycle offset from ap_start plus output
// values); the monitor pops one per cycle in which the DUT writes or pulses.
module tb_kernel_pr_dataflow_start_ctrl;
  typedef struct {
    int         off;
    logic [3:0] sw;
    logic       rdy;
    logic       dn;
    logic       idle;
    logic       er;
  } ev_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0 = 0;
  ev_t  exp_q[$];
  ev_t  ev;
  logic       auto_done;
  logic [3:0] manual_done;
  logic [3:0] pipe [6];

  kernel_pr_dataflow_start_ctrl_if #(.NUM_PROC(4), .ITER_W(32)) bus_if ();

  kernel_pr_dataflow_start_ctrl #(.NUM_PROC(4), .ITER_W(32), .MAX_INFLIGHT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Child model: done 5 cycles after each write when auto_done, plus manual pulses.
  initial begin
    for (int i = 0; i < 6; i++) pipe[i] = 4'b0;
    bus_if.proc_done = 4'b0;
    forever begin
      @(negedge clk);
      for (int i = 5; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = bus_if.start_write;
      if (reset) for (int i = 0; i < 6; i++) pipe[i] = 4'b0;
      bus_if.proc_done = (auto_done ? pipe[5] : 4'b0) | manual_done;
    end
  end

  // Monitor: compare every active cycle against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (bus_if.start_write != 4'b0 || bus_if.ap_ready || bus_if.ap_done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event off=%0d sw=%b rdy=%b done=%b required=none",
                   cyc - t0, bus_if.start_write, bus_if.ap_ready, bus_if.ap_done);
        end else begin
          ev = exp_q.pop_front();
          if ((cyc - t0) != ev.off || bus_if.start_write !== ev.sw || bus_if.ap_ready !== ev.rdy ||
              bus_if.ap_done !== ev.dn || bus_if.ap_idle !== ev.idle || bus_if.err !== ev.er) begin
            errors++;
            $display("FAIL event got off=%0d sw=%b rdy=%b done=%b idle=%b err=%b required off=%0d sw=%b rdy=%b done=%b idle=%b err=%b",
                     cyc - t0, bus_if.start_write, bus_if.ap_ready, bus_if.ap_done, bus_if.ap_idle, bus_if.err,
                     ev.off, ev.sw, ev.rdy, ev.dn, ev.idle, ev.er);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic push(input int off, input logic [3:0] sw, input logic rdy, input logic dn,
                      input logic idle, input logic er);
    ev_t e;
    e.off = off; e.sw = sw; e.rdy = rdy; e.dn = dn; e.idle = idle; e.er = er;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int off);
    while (cyc < t0 + off) tick();
  endtask

  task automatic start_run(input int n);
    t0 = cyc;
    bus_if.ap_start = 1'b1;
    bus_if.num_iter = n;
    tick();
    bus_if.ap_start = 1'b0;
  endtask

  task automatic done_at(input int off, input logic [3:0] mask);
    goto(off);
    manual_done = mask;
    tick();
    manual_done = 4'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, want);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (8) tick();
  endtask

  initial begin
    reset = 1'b1;
    auto_done = 1'b0;
    manual_done = 4'b0;
    bus_if.ap_start = 1'b0;
    bus_if.num_iter = 32'd0;
    bus_if.start_full_n = 4'hF;
    repeat (2) tick();
    reset = 1'b0;
    chk("reset_idle", {31'd0, bus_if.ap_idle}, 32'd1);
    chk("reset_ready", {31'd0, bus_if.ap_ready}, 32'd0);
    chk("reset_done", {31'd0, bus_if.ap_done}, 32'd0);
    chk("reset_sw", {28'd0, bus_if.start_write}, 32'd0);
    chk("reset_err", {31'd0, bus_if.err}, 32'd0);
    repeat (2) tick();

    // 1: three iterations, children answer after 5 cycles.
    auto_done = 1'b1;
    push(1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    push(2, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    push(3, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    push(4, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(10, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    start_run(3);
    wait_drain("t1");
    chk("t1_idle", {31'd0, bus_if.ap_idle}, 32'd1);

    // 2: in-flight limit of 4; each retire releases one iteration.
    auto_done = 1'b0;
    for (int i = 1; i <= 4; i++) push(i, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) push(10 + 5 * i, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    push(26, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(33, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    start_run(8);
    for (int i = 0; i < 4; i++) done_at(8 + 5 * i, 4'hF);
    for (int i = 0; i < 4; i++) done_at(28 + i, 4'hF);
    wait_drain("t2");

    // 3: child 2 full for 10 cycles; siblings write iteration 0 immediately.
    auto_done = 1'b1;
    bus_if.start_full_n = 4'b1011;
    push(1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
    push(10, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    push(11, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    push(12, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(18, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    start_run(2);
    goto(10);
    bus_if.start_full_n = 4'hF;
    wait_drain("t3");

    // 4: zero-iteration run.
    push(1, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    start_run(0);
    chk("t4_idle", {31'd0, bus_if.ap_idle}, 32'd1);
    wait_drain("t4");

    // 5: reset after two iterations, then a fresh single-iteration run.
    auto_done = 1'b0;
    push(1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    push(2, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    start_run(5);
    goto(2);
    reset = 1'b1;
    goto(3);
    reset = 1'b0;
    chk("t5_sw_after_reset", {28'd0, bus_if.start_write}, 32'd0);
    chk("t5_idle_after_reset", {31'd0, bus_if.ap_idle}, 32'd1);
    chk("t5_ready_after_reset", {31'd0, bus_if.ap_ready}, 32'd0);
    wait_drain("t5a");
    auto_done = 1'b1;
    push(1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    push(2, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(8, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    start_run(1);
    wait_drain("t5b");

    // 6: pend[1] overflow sets err; run still completes; then proc_done in IDLE.
    auto_done = 1'b0;
    for (int i = 1; i <= 4; i++) push(i, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    push(5, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(17, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    start_run(4);
    for (int i = 0; i < 4; i++) done_at(6 + i, 4'b0010);
    chk("t6_err_before_ovf", {31'd0, bus_if.err}, 32'd0);
    done_at(10, 4'b0010);
    chk("t6_err_ovf", {31'd0, bus_if.err}, 32'd1);
    for (int i = 0; i < 4; i++) done_at(12 + i, 4'b1101);
    wait_drain("t6");
    chk("t6_err_sticky", {31'd0, bus_if.err}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_err_cleared", {31'd0, bus_if.err}, 32'd0);
    manual_done = 4'b0001;
    tick();
    manual_done = 4'b0;
    chk("t6_err_idle_done", {31'd0, bus_if.err}, 32'd1);
    repeat (5) tick();
    chk("t6_err_idle_sticky", {31'd0, bus_if.err}, 32'd1);
    chk("t6_idle_after_err", {31'd0, bus_if.ap_idle}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_err_reset", {31'd0, bus_if.err}, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
